// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - RV32I branch resolve, mispredict detect, counter-table predictor
//
// Resolves conditional branches in EX from ALU flags (rs1-rs2), flags
// mispredicts against the prediction carried from IF, trains a table of
// saturating counters indexed by PC, and returns a registered prediction
// to IF one cycle after each request.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req, if_pc                 prediction request from IF
//   if_pred_valid, if_pred_taken  registered prediction (1-cycle latency)
//   ex_valid, ex_branch           EX holds a live conditional branch
//   ex_funct3, ex_pc              branch type and PC
//   ex_pred_taken                 prediction that travelled with the branch
//   cf, zf, sf, vf                ALU flags, cf=1 means no borrow
//   branch_condition              branch taken (combinational)
//   mispredict                    flush request (combinational)
//   illegal_branch                funct3 010/011 (combinational)
//   cnt_clr                       synchronous clear of the event counters
//   br_count, mis_count           resolved-branch and mispredict counters
module branch_resolve_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_valid,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             cf,
    input  logic             zf,
    input  logic             sf,
    input  logic             vf,
    output logic             branch_condition,
    output logic             mispredict,
    output logic             illegal_branch,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly-not-taken: just below the MSB threshold.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

    logic [IDX_W-1:0]    ex_idx;
    logic [IDX_W-1:0]    if_idx;
    logic                act;
    logic                legal;
    logic                train;
    logic                cond_raw;
    logic [CTR_BITS-1:0] cur_ctr;
    logic [CTR_BITS-1:0] next_ctr;
    logic                unused_pc_bits;

    // Word-aligned PCs: bits [1:0] never contribute to the index.
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_idx = if_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    assign act   = ex_valid & ex_branch;
    assign legal = (ex_funct3 != 3'b010) && (ex_funct3 != 3'b011);
    assign train = act & legal;

    always_comb begin
        cond_raw = 1'b0;
        case (ex_funct3)
            3'b000:  cond_raw = zf;
            3'b001:  cond_raw = ~zf;
            3'b100:  cond_raw = sf ^ vf;
            3'b101:  cond_raw = ~(sf ^ vf);
            3'b110:  cond_raw = ~cf;
            3'b111:  cond_raw = cf;
            default: cond_raw = 1'b0;
        endcase
    end

    assign branch_condition = train & cond_raw;
    assign mispredict       = train & (branch_condition != ex_pred_taken);
    assign illegal_branch   = act & ~legal;

    // Saturating step of the counter being trained this cycle.
    assign cur_ctr = bht[ex_idx];
    always_comb begin
        next_ctr = cur_ctr;
        if (branch_condition) begin
            if (cur_ctr != CTR_MAX) next_ctr = cur_ctr + CTR_BITS'(1);
        end else begin
            if (cur_ctr != '0) next_ctr = cur_ctr - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
            if_pred_valid <= 1'b0;
            if_pred_taken <= 1'b0;
            br_count      <= '0;
            mis_count     <= '0;
        end else begin
            if (train) bht[ex_idx] <= next_ctr;

            if (if_req) begin
                if_pred_valid <= 1'b1;
                // Bypass so a same-edge update is visible to the prediction.
                if (train && (ex_idx == if_idx))
                    if_pred_taken <= next_ctr[CTR_BITS-1];
                else
                    if_pred_taken <= bht[if_idx][CTR_BITS-1];
            end else begin
                if_pred_valid <= 1'b0;
            end

            if (cnt_clr) begin
                br_count  <= '0;
                mis_count <= '0;
            end else begin
                if (train)      br_count  <= br_count + CNT_W'(1);
                if (mispredict) mis_count <= mis_count + CNT_W'(1);
            end
        end
    end
endmodule
